// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit CLA stage reused once per nibble.
// Valid/ready on both sides; result held in DONE until consumed.

module cla4_stage (
  output logic [3:0] sum,
  output logic       cout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms and two-level look-ahead carries
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [3:0]    st_sum;
  logic          st_cout;
  logic [W-1:0]  nib_mask;
  logic [W-1:0]  nib_val;

  // Select the current nibble of each captured operand
  always_comb begin
    nib_a    = 4'(a_q >> (4 * idx_q));
    nib_b    = 4'(b_q >> (4 * idx_q));
    nib_mask = W'(4'hF) << (4 * idx_q);
    nib_val  = W'(st_sum) << (4 * idx_q);
  end

  cla4_stage u_cla (
    .sum  (st_sum),
    .cout (st_cout),
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q)
  );

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~nib_mask) | nib_val;
        carry_d = st_cout;
        if (idx_q == LAST) begin
          cout_d  = st_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1])
                  && (st_sum[3] != a_q[W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with NIBBLES=4.
// Expected values below are hand-computed.

module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept, count latency, check result, then consume it
  task automatic run_op(input string tag,
                        input logic [W-1:0] va,
                        input logic [W-1:0] vb,
                        input logic vc,
                        input logic [W-1:0] es,
                        input logic ec,
                        input logic eo);
    a         = va;
    b         = vb;
    cin       = vc;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b1;
    a        = ~va;
    b        = 16'h1111;
    cin      = ~vc;
    for (int k = 1; k <= N; k++) begin
      tick();
      if (k < N && out_valid !== 1'b0) begin
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
      end
    end
    in_valid = 1'b0;
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 16'hAAAA;
    b         = 16'h5555;
    cin       = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    tick();
    chk("rst_no_accept", 32'(in_ready), 32'd1);

    run_op("nocarry", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("maxop", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("cinonly", 16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0);

    // Back-pressure: hold out_ready low in DONE
    a         = 16'h0F0F;
    b         = 16'h00F1;
    cin       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) tick();
    chk("bp_vld0", 32'(out_valid), 32'd1);
    chk("bp_sum0", 32'(sum), 32'h1000);
    in_valid = 1'b1;
    a        = 16'h1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_vld", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'h1000);
      chk("bp_cout", 32'(cout), 32'd0);
      chk("bp_ovf", 32'(ovf), 32'd0);
      chk("bp_inrdy", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_rel_vld", 32'(out_valid), 32'd0);
    chk("bp_rel_inrdy", 32'(in_ready), 32'd1);

    // Reset sampled at the second RUN edge
    a        = 16'h1234;
    b        = 16'h4321;
    cin      = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_inrdy", 32'(in_ready), 32'd1);
    chk("mid_vld", 32'(out_valid), 32'd0);
    chk("mid_sum", 32'(sum), 32'd0);
    chk("mid_cout", 32'(cout), 32'd0);
    chk("mid_ovf", 32'(ovf), 32'd0);
    run_op("post", 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit nibbles per operand (legal 1..16); operand width W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  operand set offered.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  W  operand A, unsigned or two's complement.
REQ-007 b  input  W  operand B.
REQ-008 cin  input  1  carry into nibble 0.
REQ-009 out_valid  output  1  result registers hold a completed result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  W  registered result, (a + b + cin) mod 2^W.
REQ-012 cout  output  1  carry out of the most significant nibble.
REQ-013 ovf  output  1  signed overflow: a[W-1] == b[W-1] and sum[W-1] != a[W-1].

Function
REQ-014 The block shall instantiate exactly one 4-bit carry-look-ahead adder stage, ports (sum, cout, a, b, cin), and reuse it once per nibble.
REQ-015 State machine states shall be IDLE, RUN and DONE.
REQ-016 In IDLE, in_ready shall be 1; out_valid shall be 0.
REQ-017 A transfer shall occur on an edge where in_valid and in_ready are both 1: a, b and cin are captured, the nibble index is cleared to 0, and the state becomes RUN.
REQ-018 In RUN, in_ready shall be 0, and each cycle shall add nibble k of the captured A and B plus the carry register through the CLA stage.
REQ-019 At the edge that ends that cycle, sum[4k+3:4k] shall take the stage sum, the carry register shall take the stage cout, and k shall increment.
REQ-020 The carry register shall be loaded with cin at capture.
REQ-021 After nibble NIBBLES-1 is processed, the state shall become DONE, cout shall take the final carry, and ovf shall be computed from the captured MSBs and the final sum MSB.
REQ-022 out_valid shall rise exactly NIBBLES clock edges after the accepting edge.
REQ-023 In DONE, out_valid shall be 1, and sum, cout and ovf shall be held stable until out_valid and out_ready are both 1.
REQ-024 On that handshake edge the state shall return to IDLE; in_ready rises the following cycle (no same-cycle accept in DONE).
REQ-025 Changes on a, b, cin or in_valid while in RUN or DONE shall have no effect.
REQ-026 out_ready shall be ignored outside DONE.
REQ-027 Carries beyond bit W-1 shall appear only on cout; sum wraps modulo 2^W.
REQ-028 For NIBBLES=1, the block shall enter DONE one edge after accept.
REQ-029 Throughput shall be one result per NIBBLES+2 cycles at most, with out_ready held high.

Reset
REQ-030 While rst=1 at an edge: state shall go to IDLE; in_ready=1; out_valid=0; sum=0; cout=0; ovf=0; carry register=0; nibble index=0.
REQ-031 Reset shall take priority over every handshake, including an assertion mid-RUN or mid-DONE; any partial result shall be discarded.
REQ-032 An in_valid presented during the reset edge shall not be accepted.

Verification (NIBBLES=4)
REQ-033 Add without carry: a=0x1234, b=0x4321, cin=0 -> out_valid 4 edges after accept with sum=0x5555, cout=0, ovf=0.
REQ-034 Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
REQ-035 Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-036 Maximum operands: a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0.
REQ-037 Back-pressure: out_ready held 0 for 3 cycles in DONE -> sum, cout, ovf and out_valid stay constant and in_ready stays 0; out_ready=1 -> IDLE next edge, then in_ready=1.
REQ-038 Reset mid-RUN: rst asserted at the 2nd RUN edge -> next cycle IDLE, all outputs 0, in_ready=1; the following operation a=0x0005, b=0x0003 -> sum=0x0008.
